// File: rtl/read_data_resp.sv
// read_data_resp: cache read-response path (hit word select, refill assembly, masked return).
// Define READ_EARLY_RESP_EN to return the critical word while the refill is still in progress.
module read_data_resp #(
    parameter int CASH_STR_WIDTH = 64,
    parameter int OFFSET_WIDTH   = 3,
    parameter int MEM_BUS_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [OFFSET_WIDTH-1:0]   req_offset,
    input  logic [3:0]                req_bval,
    input  logic                      hit,
    input  logic [CASH_STR_WIDTH-1:0] hit_data,
    input  logic                      mem_rvalid,
    input  logic [MEM_BUS_WIDTH-1:0]  mem_rdata,
    output logic                      fill_valid,
    output logic [CASH_STR_WIDTH-1:0] fill_data,
    output logic                      sys_rvalid,
    input  logic                      sys_rready,
    output logic [31:0]               sys_rdata
);
    localparam int BEATS = CASH_STR_WIDTH / MEM_BUS_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam int WW    = OFFSET_WIDTH - 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CASH_STR_WIDTH-1:0] line_q, line_d;
    logic [CASH_STR_WIDTH-1:0] fill_data_q, fill_data_d;
    logic [WW-1:0]             w_q, w_d;
    logic [3:0]                bval_q, bval_d;
    logic                      fill_valid_q, fill_valid_d;
    logic                      sys_rvalid_q, sys_rvalid_d;
    logic [31:0]               sys_rdata_q, sys_rdata_d;
    logic                      handshake;
    logic                      unused_ok;

    function automatic logic [31:0] pick(input logic [CASH_STR_WIDTH-1:0] line,
                                         input logic [WW-1:0] w, input logic [3:0] be);
        logic [31:0] word;
        word = line[32*w +: 32];
        for (int i = 0; i < 4; i++) pick[8*i +: 8] = be[i] ? word[8*i +: 8] : 8'h00;
    endfunction

`ifdef READ_EARLY_RESP_EN
    logic             done_q, done_d;
    logic [CNT_W-1:0] crit;
    // beat that completes the requested word
    assign crit = CNT_W'((32'(w_q) * 32 + 31) / MEM_BUS_WIDTH);
`endif

    assign handshake  = sys_rvalid_q & sys_rready;
    assign unused_ok  = ^req_offset[1:0];
    assign req_ready  = (state_q == IDLE);
    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_data_q;
    assign sys_rvalid = sys_rvalid_q;
    assign sys_rdata  = sys_rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        fill_data_d  = fill_data_q;
        w_d          = w_q;
        bval_d       = bval_q;
        fill_valid_d = 1'b0;
        sys_rvalid_d = sys_rvalid_q;
        sys_rdata_d  = sys_rdata_q;
`ifdef READ_EARLY_RESP_EN
        done_d       = done_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                w_d    = req_offset[OFFSET_WIDTH-1:2];
                bval_d = req_bval;
                cnt_d  = '0;
`ifdef READ_EARLY_RESP_EN
                done_d = 1'b0;
`endif
                if (hit) begin
                    line_d       = hit_data;
                    state_d      = RESP;
                    sys_rvalid_d = 1'b1;
                    sys_rdata_d  = pick(hit_data, req_offset[OFFSET_WIDTH-1:2], req_bval);
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
`ifdef READ_EARLY_RESP_EN
                if (handshake) begin
                    sys_rvalid_d = 1'b0;
                    done_d       = 1'b1;
                end
`endif
                if (mem_rvalid) begin
                    line_d[cnt_q*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] = mem_rdata;
                    cnt_d = cnt_q + 1'b1;
`ifdef READ_EARLY_RESP_EN
                    if (cnt_q == crit) begin
                        sys_rvalid_d = 1'b1;
                        sys_rdata_d  = pick(line_d, w_q, bval_q);
                    end
`endif
                    if (cnt_q == LAST) begin
                        cnt_d        = '0;
                        fill_data_d  = line_d;
                        fill_valid_d = 1'b1;
`ifdef READ_EARLY_RESP_EN
                        state_d      = (done_q | handshake) ? IDLE : RESP;
`else
                        state_d      = RESP;
                        sys_rvalid_d = 1'b1;
                        sys_rdata_d  = pick(line_d, w_q, bval_q);
`endif
                    end
                end
            end
            RESP: if (handshake) begin
                state_d      = IDLE;
                sys_rvalid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            fill_data_q  <= '0;
            w_q          <= '0;
            bval_q       <= '0;
            fill_valid_q <= 1'b0;
            sys_rvalid_q <= 1'b0;
            sys_rdata_q  <= '0;
`ifdef READ_EARLY_RESP_EN
            done_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            fill_data_q  <= fill_data_d;
            w_q          <= w_d;
            bval_q       <= bval_d;
            fill_valid_q <= fill_valid_d;
            sys_rvalid_q <= sys_rvalid_d;
            sys_rdata_q  <= sys_rdata_d;
`ifdef READ_EARLY_RESP_EN
            done_q       <= done_d;
`endif
        end
    end
endmodule
